pipe_issue_collect: RTL and testbench

//  Stream-side partner for the fixed-latency arithmetic pipeline (operands A..D in, F out).

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/sync_fifo_fwft.sv | 64 ++++++
 rtl/pipe_issue_collect.sv | 109 ++++++++++
 tb/tb_pipe_issue_collect.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and types for the pipeline issue/collect block.
package pipe_pkg;

  localparam int unsigned DEF_W     = 10;
  localparam int unsigned DEF_LAT   = 2;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CW    = $clog2(DEF_DEPTH + 1);

  // One operand set as presented to the arithmetic pipeline.
  typedef struct packed {
    logic [DEF_W-1:0] a;
    logic [DEF_W-1:0] b;
    logic [DEF_W-1:0] c;
    logic [DEF_W-1:0] d;
  } opset_t;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; depth need not be a power of two.
module sync_fifo_fwft
  import pipe_pkg::*;
#(
  parameter  int unsigned W     = DEF_W,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Pointer increment with explicit wrap at DEPTH.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/pipe_issue_collect.sv
// Issues operand sets into a fixed-latency pipeline and collects results in order,
// reserving a FIFO slot per issued op so no result is ever dropped.
module pipe_issue_collect
  import pipe_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LAT   = DEF_LAT,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] pa,
  output logic [W-1:0] pb,
  output logic [W-1:0] pc,
  output logic [W-1:0] pd,
  input  logic [W-1:0] pf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_f,
  output logic         busy
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [LAT:0]  r_vsr;
  logic [W-1:0]  r_pa;
  logic [W-1:0]  r_pb;
  logic [W-1:0]  r_pc;
  logic [W-1:0]  r_pd;
  logic          w_issue;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [W-1:0]  w_dout;
  logic [31:0]   w_inflight;
  logic          w_credit_ok;

  // Occupancy = buffered results plus ops still travelling down the pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= int'(LAT); i++) begin
      w_inflight = w_inflight + 32'(r_vsr[i]);
    end
    w_credit_ok = !w_full && ((32'(w_count) + w_inflight) < 32'(DEPTH));
  end

  assign in_ready = !rst && w_credit_ok;
  assign w_issue  = in_valid && in_ready;
  assign w_pop    = !w_empty && out_ready;

  // Operand registers feeding the pipeline; hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pa <= '0;
      r_pb <= '0;
      r_pc <= '0;
      r_pd <= '0;
    end else if (w_issue) begin
      r_pa <= in_a;
      r_pb <= in_b;
      r_pc <= in_c;
      r_pd <= in_d;
    end
  end

  // Valid shift register mirroring ops through the pipeline stages.
  if (LAT == 0) begin : g_vsr_lat0
    always_ff @(posedge clk) begin
      if (rst) r_vsr <= '0;
      else     r_vsr <= w_issue;
    end
  end else begin : g_vsr_latn
    always_ff @(posedge clk) begin
      if (rst) r_vsr <= '0;
      else     r_vsr <= {r_vsr[LAT-1:0], w_issue};
    end
  end

  sync_fifo_fwft #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_vsr[LAT]),
    .din   (pf),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign pa        = r_pa;
  assign pb        = r_pb;
  assign pc        = r_pc;
  assign pd        = r_pd;
  assign out_valid = !w_empty;
  assign out_f     = w_dout;
  assign busy      = (|r_vsr) || !w_empty;

endmodule

// File: tb/tb_pipe_issue_collect.sv
// Directed bench for pipe_issue_collect with a stub pipeline F=(A+B)+(C-D), LAT=2.
module tb_pipe_issue_collect;
  import pipe_pkg::*;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] in_c = '0;
  logic [W-1:0] in_d = '0;
  logic         in_ready;
  logic [W-1:0] pa, pb, pc, pd, pf, out_f;
  logic         out_valid, busy;

  int n_chk = 0;
  int n_err = 0;

  opset_t vec [8];

  always #5 clk = ~clk;

  pipe_issue_collect #(.W(W), .LAT(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .pd        (pd),
    .pf        (pf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .busy      (busy)
  );

  // Stub pipeline: two register stages after the combinational result.
  logic [W-1:0] s1 = '0;
  logic [W-1:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= W'((pa + pb) + (pc - pd));
    s2 <= s1;
  end
  assign pf = s2;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input opset_t op);
    in_a = op.a;
    in_b = op.b;
    in_c = op.c;
    in_d = op.d;
  endtask

  task automatic chk_ops(input string tag, input opset_t op);
    chk({tag, "_pa"}, 32'(pa), 32'(op.a));
    chk({tag, "_pb"}, 32'(pb), 32'(op.b));
    chk({tag, "_pc"}, 32'(pc), 32'(op.c));
    chk({tag, "_pd"}, 32'(pd), 32'(op.d));
  endtask

  initial begin
    vec[0] = '{a: 10'd10,   b: 10'd12,  c: 10'd6,  d: 10'd3};   // 25
    vec[1] = '{a: 10'd10,   b: 10'd10,  c: 10'd5,  d: 10'd4};   // 21
    vec[2] = '{a: 10'd20,   b: 10'd11,  c: 10'd1,  d: 10'd5};   // 27
    vec[3] = '{a: 10'd1,    b: 10'd2,   c: 10'd3,  d: 10'd4};   // 2
    vec[4] = '{a: 10'd100,  b: 10'd200, c: 10'd50, d: 10'd25};  // 325
    vec[5] = '{a: 10'd1000, b: 10'd30,  c: 10'd0,  d: 10'd0};   // 6 (wraps)
    vec[6] = '{a: 10'd0,    b: 10'd0,   c: 10'd0,  d: 10'd1};   // 1023 (wraps)
    vec[7] = '{a: 10'd5,    b: 10'd5,   c: 10'd5,  d: 10'd5};   // 10

    // 1: reset with in_valid asserted
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    drive(vec[4]);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk_ops("rst", '0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk_ops("post_rst", '0);

    // 2: single op
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(vec[0]);
    tick();
    in_valid = 1'b0;
    drive(vec[5]);
    chk_ops("single_e0", vec[0]);
    chk("single_e0_valid", 32'(out_valid), 32'd0);
    chk("single_e0_busy", 32'(busy), 32'd1);
    tick();
    chk("single_e1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_e2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_e3_valid", 32'(out_valid), 32'd1);
    chk("single_e3_f", 32'(out_f), 32'd25);
    chk("single_e3_busy", 32'(busy), 32'd1);
    tick();
    chk("single_pop_valid", 32'(out_valid), 32'd0);
    chk("single_pop_busy", 32'(busy), 32'd0);
    chk("single_pop_f", 32'(out_f), 32'd0);
    chk_ops("single_hold", vec[0]);

    // 3: back-to-back issue
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(vec[i]);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_pre_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b2b_r0_valid", 32'(out_valid), 32'd1);
    chk("b2b_r0_f", 32'(out_f), 32'd25);
    tick();
    chk("b2b_r1_valid", 32'(out_valid), 32'd1);
    chk("b2b_r1_f", 32'(out_f), 32'd21);
    tick();
    chk("b2b_r2_valid", 32'(out_valid), 32'd1);
    chk("b2b_r2_f", 32'(out_f), 32'd27);
    tick();
    chk("b2b_done_valid", 32'(out_valid), 32'd0);
    chk("b2b_done_busy", 32'(busy), 32'd0);

    // 4: backpressure fills to DEPTH, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(vec[3]); chk("bp_rdy0", 32'(in_ready), 32'd1); tick();
    drive(vec[4]); chk("bp_rdy1", 32'(in_ready), 32'd1); tick();
    drive(vec[5]); chk("bp_rdy2", 32'(in_ready), 32'd1); tick();
    drive(vec[7]); chk("bp_rdy3", 32'(in_ready), 32'd1); tick();
    drive(vec[6]);
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_held_rdy", 32'(in_ready), 32'd0);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    chk("bp_held_f", 32'(out_f), 32'd2);
    chk("bp_held_busy", 32'(busy), 32'd1);
    chk_ops("bp_no_issue", vec[7]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_d0", 32'(out_f), 32'd2);   tick();
    chk("bp_d1_valid", 32'(out_valid), 32'd1);
    chk("bp_d1", 32'(out_f), 32'd325); tick();
    chk("bp_d2_valid", 32'(out_valid), 32'd1);
    chk("bp_d2", 32'(out_f), 32'd6);   tick();
    chk("bp_d3_valid", 32'(out_valid), 32'd1);
    chk("bp_d3", 32'(out_f), 32'd10);  tick();
    chk("bp_drained_valid", 32'(out_valid), 32'd0);
    chk("bp_drained_busy", 32'(busy), 32'd0);
    chk("bp_drained_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    drive(vec[6]);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bp_resume_valid", 32'(out_valid), 32'd1);
    chk("bp_resume_f", 32'(out_f), 32'd1023);
    tick();
    chk("bp_resume_pop", 32'(out_valid), 32'd0);

    // 5: pop and push on the same edge at full occupancy
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("pp_full_rdy", 32'(in_ready), 32'd0);
    chk("pp_head", 32'(out_f), 32'd25);
    out_ready = 1'b1;
    tick();
    chk("pp_after_rdy", 32'(in_ready), 32'd1);
    chk("pp_r1_valid", 32'(out_valid), 32'd1);
    chk("pp_r1", 32'(out_f), 32'd21);
    tick();
    chk("pp_r2_valid", 32'(out_valid), 32'd1);
    chk("pp_r2", 32'(out_f), 32'd27);
    tick();
    chk("pp_r3_valid", 32'(out_valid), 32'd1);
    chk("pp_r3", 32'(out_f), 32'd2);
    tick();
    chk("pp_empty_valid", 32'(out_valid), 32'd0);
    chk("pp_empty_busy", 32'(busy), 32'd0);

    // 6: reset with two ops in flight and one buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(vec[4]); tick();
    drive(vec[5]); tick();
    drive(vec[7]); tick();
    in_valid = 1'b0;
    tick();
    chk("mid_buf_valid", 32'(out_valid), 32'd1);
    chk("mid_buf_f", 32'(out_f), 32'd325);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    chk("mid_rst_f", 32'(out_f), 32'd0);
    chk_ops("mid_rst", '0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("mid_stale_valid", 32'(out_valid), 32'd0);
    chk("mid_stale_busy", 32'(busy), 32'd0);
    chk("mid_stale_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(vec[2]);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_new_valid", 32'(out_valid), 32'd1);
    chk("mid_new_f", 32'(out_f), 32'd27);
    tick();
    chk("mid_new_pop", 32'(out_valid), 32'd0);
    chk("mid_new_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
